// File: rtl/video_pkg.sv
// Shared VGA 640x480@60 timing constants and raster types for the video path.
package video_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int FRAME_SZ    = VGA_H_ACTIVE * VGA_V_ACTIVE;
  localparam int ADDR_W      = $clog2(FRAME_SZ);

  // Raster run state: idle holds the counters at the frame origin
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } raster_state_t;

  // Per-position timing flags carried through the read-latency pipe
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
    logic first;
  } raster_flags_t;

  // Map an asserted/deasserted sync condition to the pin level
  function automatic logic sync_level(input logic asserted, input logic pol);
    return asserted ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters and raw (undelayed) timing flags for a VGA-style display.
module vga_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic active,
  output logic hs_raw,
  output logic vs_raw,
  output logic first_pixel
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  raster_state_t state;
  logic          run;

  // Run state and raster counters; origin is held until the first run cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!enable) begin
      state <= ST_IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      state <= ST_RUN;
      if (state == ST_RUN) begin
        if (h_cnt == HW'(H_TOTAL - 1)) begin
          h_cnt <= '0;
          if (v_cnt == VW'(V_TOTAL - 1)) v_cnt <= '0;
          else                           v_cnt <= v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  // Raw flags; gating on enable too makes a dropped enable blank the pipe input at once
  always_comb begin
    run         = (state == ST_RUN) && enable;
    active      = run && (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    hs_raw      = run && (h_cnt >= HW'(HS_START)) && (h_cnt < HW'(HS_END));
    vs_raw      = run && (v_cnt >= VW'(VS_START)) && (v_cnt < VW'(VS_END));
    first_pixel = active && (h_cnt == '0) && (v_cnt == '0);
  end

endmodule

// File: rtl/frame_buffer_reader.sv
// Frame buffer scan-out: raster-order read address, RAM latency realignment
// and registered VGA output (pixel, hsync, vsync, de, frame_start).
module frame_buffer_reader
  import video_pkg::*;
#(
  parameter int W        = 8,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int RAM_LAT  = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   enable,
  input  logic [W-1:0]                           ram_q,
  output logic [$clog2(H_ACTIVE*V_ACTIVE)-1:0]   read_address,
  output logic [W-1:0]                           pixel,
  output logic                                   hsync,
  output logic                                   vsync,
  output logic                                   de,
  output logic                                   frame_start
);

  localparam int          PIX_CNT = H_ACTIVE * V_ACTIVE;
  localparam int          AW      = $clog2(PIX_CNT);
  localparam int unsigned LAT     = RAM_LAT;

  logic          active;
  logic          hs_raw;
  logic          vs_raw;
  logic          first_pixel;
  raster_flags_t raw;
  raster_flags_t pipe [LAT];
  raster_flags_t tail;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .active      (active),
    .hs_raw      (hs_raw),
    .vs_raw      (vs_raw),
    .first_pixel (first_pixel)
  );

  // Bundle the raw flags for the latency pipe
  always_comb begin
    raw       = '0;
    raw.active = active;
    raw.hs     = hs_raw;
    raw.vs     = vs_raw;
    raw.first  = first_pixel;
    tail       = pipe[LAT-1];
  end

  // Linear read address: advances on active cycles, wraps after the last pixel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_address <= '0;
    end else if (!enable) begin
      read_address <= '0;
    end else if (active) begin
      if (read_address == AW'(PIX_CNT - 1)) read_address <= '0;
      else                                  read_address <= read_address + 1'b1;
    end
  end

  // Delay timing flags by the RAM read latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= raw;
      for (int unsigned i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Output register: data and timing leave the block on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel       <= '0;
      de          <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      pixel       <= tail.active ? ram_q : '0;
      de          <= tail.active;
      hsync       <= sync_level(tail.hs, SYNC_POL);
      vsync       <= sync_level(tail.vs, SYNC_POL);
      frame_start <= tail.first;
    end
  end

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Directed bench for frame_buffer_reader: full 640-wide lines with a short
// 4-line frame (10 lines total) so two whole frames fit in a short run.
module tb_frame_buffer_reader;

  localparam int HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int VA = 4, VF = 2, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;   // 800
  localparam int VT = VA + VF + VS + VB;   // 10
  localparam int FR = HT * VT;             // 8000 cycles per frame
  localparam int NPIX = HA * VA;           // 2560 pixels

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  ram_q;
  logic [7:0]  ram_r1;
  logic [11:0] read_address;
  logic [7:0]  pixel;
  logic        hsync, vsync, de, frame_start;

  int n_checks;
  int n_fail;

  frame_buffer_reader #(
    .W        (8),
    .H_ACTIVE (HA),
    .H_FP     (HF),
    .H_SYNC   (HS),
    .H_BP     (HB),
    .V_ACTIVE (VA),
    .V_FP     (VF),
    .V_SYNC   (VS),
    .V_BP     (VB),
    .SYNC_POL (1'b0),
    .RAM_LAT  (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .ram_q        (ram_q),
    .read_address (read_address),
    .pixel        (pixel),
    .hsync        (hsync),
    .vsync        (vsync),
    .de           (de),
    .frame_start  (frame_start)
  );

  always #5 clk = ~clk;

  // Two-cycle read RAM holding mem[i] = i[7:0]
  always @(posedge clk) begin
    ram_r1 <= read_address[7:0];
    ram_q  <= ram_r1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected pin values for the raster position shown at the outputs
  function automatic void model(input int pos, output logic e_de, output logic e_hs,
                                output logic e_vs, output logic e_fs, output logic [7:0] e_px);
    int h, v;
    if (pos < 0) begin
      e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0; e_px = 8'd0;
    end else begin
      h    = pos % HT;
      v    = (pos / HT) % VT;
      e_de = (h < HA) && (v < VA);
      e_hs = !((h >= HA + HF) && (h < HA + HF + HS));
      e_vs = !((v >= VA + VF) && (v < VA + VF + VS));
      e_fs = e_de && (h == 0) && (v == 0);
      e_px = e_de ? 8'((v * HA + h) % 256) : 8'd0;
    end
  endfunction

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic e_de, e_hs, e_vs, e_fs;
    logic [7:0] e_px;
    int err_de, err_hs, err_vs, err_fs, err_px, err_addr;
    int first_de, de_fall, de_rise2, hs_fall, hs_rise, vs_fall, vs_rise, nfs;
    int fs_k [3];
    logic p_de, p_hs, p_vs;
    int q, hq, vq, idx, first, fs_at;

    n_checks = 0; n_fail = 0;
    err_de = 0; err_hs = 0; err_vs = 0; err_fs = 0; err_px = 0; err_addr = 0;
    first_de = -1; de_fall = -1; de_rise2 = -1; hs_fall = -1; hs_rise = -1;
    vs_fall = -1; vs_rise = -1; nfs = 0; fs_k = '{-1, -1, -1};
    reset = 1'b1; enable = 1'b1;

    repeat (5) @(negedge clk);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_de", de, 0);
    check("rst_pixel", pixel, 0);
    check("rst_addr", read_address, 0);
    check("rst_fs", frame_start, 0);

    reset = 1'b0;
    p_de = 1'b0; p_hs = 1'b1; p_vs = 1'b1;
    for (int k = 1; k <= 2 * FR + 50; k++) begin
      @(negedge clk);
      model(k - 4, e_de, e_hs, e_vs, e_fs, e_px);
      if (de !== e_de) err_de++;
      if (hsync !== e_hs) err_hs++;
      if (vsync !== e_vs) err_vs++;
      if (frame_start !== e_fs) err_fs++;
      if (pixel !== e_px) err_px++;
      q  = k - 1;
      hq = q % HT;
      vq = (q / HT) % VT;
      if (hq < HA && vq < VA && read_address !== 12'(vq * HA + hq)) err_addr++;
      if (q == 3 * HT + HA - 1) check("addr_last", read_address, NPIX - 1);
      if (q == FR) check("addr_wrap", read_address, 0);
      if (k == 4 + HT) check("line1_px0", pixel, 8'h80);
      if (de && !p_de) begin
        if (first_de < 0) first_de = k;
        else if (de_rise2 < 0) de_rise2 = k;
      end
      if (!de && p_de && de_fall < 0) de_fall = k;
      if (!hsync && p_hs && hs_fall < 0) hs_fall = k;
      if (hsync && !p_hs && hs_rise < 0) hs_rise = k;
      if (!vsync && p_vs && vs_fall < 0) vs_fall = k;
      if (vsync && !p_vs && vs_rise < 0) vs_rise = k;
      if (frame_start) begin
        if (nfs < 3) fs_k[nfs] = k;
        nfs++;
      end
      p_de = de; p_hs = hsync; p_vs = vsync;
    end

    check("first_de_edge", first_de, 4);
    check("fs_first_edge", fs_k[0], 4);
    check("fs_count", nfs, 3);
    check("fs_period", fs_k[1] - fs_k[0], FR);
    check("de_len", de_fall - first_de, 640);
    check("line_period", de_rise2 - first_de, 800);
    check("hs_low_len", hs_rise - hs_fall, 96);
    check("hs_to_de", de_rise2 - hs_rise, 48);
    check("vs_low_len", vs_rise - vs_fall, 1600);
    check("vs_fall_edge", vs_fall, 4 + (VA + VF) * HT);
    check("scan_de", err_de, 0);
    check("scan_hsync", err_hs, 0);
    check("scan_vsync", err_vs, 0);
    check("scan_fs", err_fs, 0);
    check("scan_pixel", err_px, 0);
    check("scan_addr", err_addr, 0);

    // Reset at counter position h=300, v=1
    for (int i = 0; i < 10000 && read_address != 12'd940; i++) @(negedge clk);
    check("wait_addr940", read_address, 940);
    reset = 1'b1;
    #1;
    check("midrst_de", de, 0);
    check("midrst_pixel", pixel, 0);
    check("midrst_hsync", hsync, 1);
    check("midrst_vsync", vsync, 1);
    check("midrst_fs", frame_start, 0);
    check("midrst_addr", read_address, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    first = -1; fs_at = 0; idx = 0;
    for (int k = 1; k <= 20 && first < 0; k++) begin
      @(negedge clk);
      if (de) begin first = k; fs_at = frame_start; idx = pixel; end
    end
    check("rst_restart_de", first, 4);
    check("rst_restart_fs", fs_at, 1);
    check("rst_restart_px", idx, 0);

    // Enable dropped mid-frame (line 2, h=220)
    for (int i = 0; i < 10000 && read_address != 12'd1500; i++) @(negedge clk);
    check("wait_addr1500", read_address, 1500);
    enable = 1'b0;
    first = -1;
    for (int k = 1; k <= 10 && first < 0; k++) begin
      @(negedge clk);
      if (k == 1) check("endrop_addr", read_address, 0);
      if (!de) first = k;
    end
    check("endrop_edges", first, 3);
    repeat (10) @(negedge clk);
    check("idle_de", de, 0);
    check("idle_pixel", pixel, 0);
    check("idle_hsync", hsync, 1);
    check("idle_vsync", vsync, 1);

    enable = 1'b1;
    first = -1; fs_at = 0; idx = 0;
    for (int k = 1; k <= 20 && first < 0; k++) begin
      @(negedge clk);
      if (de) begin
        first = k; fs_at = frame_start; idx = read_address;
      end
    end
    check("reen_first_de", first, 4);
    check("reen_fs", fs_at, 1);
    check("reen_addr", idx, 3);
    @(negedge clk);
    check("reen_px1", pixel, 1);
    check("reen_fs_pulse", frame_start, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
